disp_bcd_ctrl: RTL and testbench
================================

Name: disp_bcd_ctrl

Overview:
- Sequencing controller that feeds the 3-digit multiplexed 7-segment driver (Drv_display).
- Accepts an unsigned binary value with a load strobe and converts it to three BCD digits iteratively, using double-dabble at one bit per clock.
- Commits all three digit codes (u, d, c) to the driver in the same cycle, so the display never shows a partially updated number.
- Flags values above 999 and shows an error pattern for them.

Parameters:
- BIN_W, 10, width of binary input; legal range 4..14.
- BLANK, 5'h10, digit code the driver renders as all segments off.
- ERR, 5'h0E, digit code shown on all three digits when the value exceeds 999.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valor  in  BIN_W  unsigned binary value to display.
- load  in  1  request to convert valor; level-sampled each edge.
- busy  out  1  high while a conversion is in progress; load is ignored while high.
- ovf  out  1  high when the last committed value was greater than 999.
- u  out  5  units digit code to driver.
- d  out  5  tens digit code to driver.
- c  out  5  hundreds digit code to driver.

Behaviour:
- Reset values (rst_n low, asynchronous): state IDLE, busy=0, ovf=0, u=0, d=0, c=0, internal shift/counter registers cleared.
  - With LZB_EN defined, d and c reset to BLANK instead of 0.
- Reset asserted mid-conversion aborts it immediately and returns the outputs to reset values; no partial commit occurs.
- States: IDLE, SHIFT, COMMIT.
- IDLE:
  - On an edge with load=1, capture valor into the binary shift register.
  - Clear the 12-bit BCD register and set cycle counter=0.
  - Latch over=(valor>999), then go to SHIFT; busy=1 from this edge.
- SHIFT, one edge per bit:
  - Every BCD nibble >=5 gets +3.
  - Then {bcd,bin} shifts left 1; counter increments.
  - After BIN_W shifts, go to COMMIT.
  - BCD carry-out beyond 12 bits is discarded; such values are always caught by over.
- COMMIT, single edge:
  - If over: u=d=c=ERR, ovf=1.
  - Else: u, d, c = units, tens, hundreds nibbles zero-extended to 5 bits; ovf=0.
  - Then busy=0, state IDLE.
- Latency: the load-sample edge is E0; outputs and busy=0 are visible after edge E(BIN_W+1). That is E11 at the default, i.e. 11 clocks.
- load held high continuously gives back-to-back conversions: a new capture on the first IDLE edge after COMMIT, a throughput of one per BIN_W+2 clocks.
- load while busy is ignored and not queued; valor is don't-care outside the sample edge.
- u, d, c, ovf hold their last committed value in every state except COMMIT and reset.
- Values 0 and 999 are legal boundaries. 1000 and up (up to 2^BIN_W-1) produce the ERR pattern.

Optional Feature:
- Macro: DISP_LZB_EN (leading-zero blanking).
- Defined:
  - At COMMIT with no overflow, c=BLANK if the hundreds nibble is 0.
  - d=BLANK if both the hundreds and tens nibbles are 0.
  - u is never blanked, so value 0 shows blank-blank-0.
  - Reset values are d=c=BLANK.
- Not defined: leading zeros are displayed as digit 0, and the BLANK parameter is unused.

Test Plan:
- Reset, then load valor=357 for one cycle -> busy=1 next edge; after 11 edges c=3, d=5, u=7, ovf=0, busy=0.
- Load valor=999, then valor=0 -> c=9, d=9, u=9; then c=0, d=0, u=0 (with DISP_LZB_EN: c=5'h10, d=5'h10, u=0).
- Load valor=1000 and valor=1023 -> u=d=c=5'h0E, ovf=1; a following load of 42 -> c=0, d=4, u=2 (LZB: c=5'h10), ovf=0.
- Load 123, then pulse load with valor=456 at edge 5 of the conversion -> second request ignored; outputs 1,2,3 and they stay there.
- Hold load=1 with valor=808 -> a new conversion every 12 clocks; outputs stable at 8,0,8; busy low for exactly 1 cycle between conversions.
- Load 500, then assert rst_n=0 at edge 6 -> outputs go to 0 immediately (asynchronously); after release, no commit of 500; a subsequent load of 7 -> u=7.

Source files
------------

// File: rtl/disp_bcd_ctrl.sv
// Binary-to-BCD sequencer for the 3-digit display driver. Double-dabble runs at one bit per clock,
// and all three digits are committed on the same edge. Define DISP_LZB_EN to blank leading zeros.
//
// state  | meaning
// IDLE   | waiting for load; outputs hold the last committed value
// SHIFT  | one double-dabble step per edge, BIN_W steps in total
// COMMIT | writes u/d/c/ovf together, then returns to IDLE
module disp_bcd_ctrl #(
  parameter int         BIN_W = 10,
  parameter logic [4:0] BLANK = 5'h10,
  parameter logic [4:0] ERR   = 5'h0E
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] valor,
  input  logic             load,
  output logic             busy,
  output logic             ovf,
  output logic [4:0]       u,
  output logic [4:0]       d,
  output logic [4:0]       c
);

  localparam int CW = $clog2(BIN_W + 1);
`ifdef DISP_LZB_EN
  localparam logic [4:0] RST_DC = BLANK;
`else
  // Leading zeros are shown as 0, so BLANK has no effect on the reset value.
  localparam logic [4:0] RST_DC = BLANK & 5'h00;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t           state_q;
  logic [BIN_W-1:0] bin_q;
  logic [11:0]      bcd_q;
  logic [CW-1:0]    cnt_q;
  logic             over_q;
  logic             busy_q;
  logic             ovf_q;
  logic [4:0]       u_q, d_q, c_q;

  logic [11:0]      bcd_adj;
  logic [4:0]       u_d, d_d, c_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    u_d = {1'b0, bcd_q[3:0]};
    d_d = {1'b0, bcd_q[7:4]};
    c_d = {1'b0, bcd_q[11:8]};
`ifdef DISP_LZB_EN
    if (bcd_q[11:8] == 4'd0) begin
      c_d = BLANK;
      if (bcd_q[7:4] == 4'd0) d_d = BLANK;
    end
`endif
    if (over_q) begin
      u_d = ERR;
      d_d = ERR;
      c_d = ERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      over_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      u_q     <= 5'd0;
      d_q     <= RST_DC;
      c_q     <= RST_DC;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            bin_q   <= valor;
            bcd_q   <= '0;
            cnt_q   <= '0;
            over_q  <= (32'(valor) > 32'd999);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // Carry out of the top nibble is dropped; such inputs are already flagged by over_q.
          bcd_q <= {bcd_adj[10:0], bin_q[BIN_W-1]};
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(BIN_W - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          u_q     <= u_d;
          d_q     <= d_d;
          c_q     <= c_d;
          ovf_q   <= over_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign ovf  = ovf_q;
  assign u    = u_q;
  assign d    = d_q;
  assign c    = c_q;

endmodule

// File: tb/tb_disp_bcd_ctrl.sv
// Bench for disp_bcd_ctrl: directed scenarios plus randomized loads and resets,
// checked every cycle against a decimal-arithmetic model of the display contents.
module tb_disp_bcd_ctrl;
  localparam int         BIN_W = 10;
  localparam logic [4:0] BLANK = 5'h10;
  localparam logic [4:0] ERR   = 5'h0E;
`ifdef DISP_LZB_EN
  localparam logic [4:0] RST_DC = BLANK;
  localparam bit         LZB = 1'b1;
`else
  localparam logic [4:0] RST_DC = 5'h00;
  localparam bit         LZB = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [BIN_W-1:0] valor = '0;
  logic             load = 1'b0;
  logic             busy, ovf;
  logic [4:0]       u, d, c;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  disp_bcd_ctrl #(.BIN_W(BIN_W), .BLANK(BLANK), .ERR(ERR)) dut (
    .clk(clk), .rst_n(rst_n), .valor(valor), .load(load),
    .busy(busy), .ovf(ovf), .u(u), .d(d), .c(c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Display contents for a value, straight from decimal arithmetic: {c, d, u}.
  function automatic logic [14:0] disp(input int v);
    logic [4:0] cc, dd, uu;
    if (v > 999) return {ERR, ERR, ERR};
    cc = 5'(v / 100);
    dd = 5'((v / 10) % 10);
    uu = 5'(v % 10);
    if (LZB && cc == 5'd0) begin
      cc = BLANK;
      if (dd == 5'd0) dd = BLANK;
    end
    return {cc, dd, uu};
  endfunction

  // Transaction model: a request occupies BIN_W+1 edges, then the display updates in one step.
  int          m_rem;
  int          m_val;
  logic [14:0] m_disp;
  logic        m_ovf;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  = 0;
      m_val  = 0;
      m_disp = {RST_DC, RST_DC, 5'd0};
      m_ovf  = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_disp = disp(m_val);
        m_ovf  = (m_val > 999);
      end
    end else if (load) begin
      m_rem = BIN_W + 1;
      m_val = int'(valor);
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en && rst_n) begin
      chk("busy", 32'(busy), 32'(m_rem > 0));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("c", 32'(c), 32'(m_disp[14:10]));
      chk("d", 32'(d), 32'(m_disp[9:5]));
      chk("u", 32'(u), 32'(m_disp[4:0]));
    end
  end

  // Present a one-cycle load; returns just after the sample edge.
  task automatic pulse_load(input int v);
    @(negedge clk);
    load  = 1'b1;
    valor = BIN_W'(v);
    @(negedge clk);
    load  = 1'b0;
    valor = BIN_W'($urandom);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic chk_out(input string tag, input logic [4:0] ec, input logic [4:0] ed,
                         input logic [4:0] eu, input logic eo);
    chk({tag, "_c"}, 32'(c), 32'(ec));
    chk({tag, "_d"}, 32'(d), 32'(ed));
    chk({tag, "_u"}, 32'(u), 32'(eu));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    int n, lows;
    logic [4:0] z;
    z = LZB ? BLANK : 5'd0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_out("rst", RST_DC, RST_DC, 5'd0, 1'b0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    pulse_load(357);
    chk("357_busy_next", 32'(busy), 32'd1);
    wait_idle(n);
    chk("357_latency", 32'(n), 32'(BIN_W + 1));
    chk_out("357", 5'd3, 5'd5, 5'd7, 1'b0);

    pulse_load(999); wait_idle(n);
    chk_out("999", 5'd9, 5'd9, 5'd9, 1'b0);
    pulse_load(0); wait_idle(n);
    chk_out("0", z, z, 5'd0, 1'b0);

    pulse_load(1000); wait_idle(n);
    chk_out("1000", ERR, ERR, ERR, 1'b1);
    pulse_load(1023); wait_idle(n);
    chk_out("1023", ERR, ERR, ERR, 1'b1);
    pulse_load(42); wait_idle(n);
    chk_out("42", z, 5'd4, 5'd2, 1'b0);

    // Second request lands on edge 5 of the conversion and must be dropped.
    pulse_load(123);
    repeat (3) @(negedge clk);
    load = 1'b1; valor = BIN_W'(456);
    @(negedge clk);
    load = 1'b0;
    wait_idle(n);
    chk_out("123", 5'd1, 5'd2, 5'd3, 1'b0);
    repeat (20) @(negedge clk);
    chk("123_still_idle", 32'(busy), 32'd0);
    chk_out("123_hold", 5'd1, 5'd2, 5'd3, 1'b0);

    // Continuous load: period BIN_W+2, one idle cycle per conversion.
    @(negedge clk);
    load = 1'b1; valor = BIN_W'(808);
    @(negedge clk);
    lows = 0;
    for (int k = 0; k < 3 * (BIN_W + 2); k++) begin
      @(negedge clk);
      if (!busy) lows++;
    end
    chk("808_idle_cycles", 32'(lows), 32'd3);
    load = 1'b0;
    wait_idle(n);
    chk_out("808", 5'd8, 5'd0, 5'd8, 1'b0);

    // Reset during a conversion: immediate clear and no late commit.
    pulse_load(500);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk_out("arst", RST_DC, RST_DC, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("arst_after_busy", 32'(busy), 32'd0);
    chk_out("arst_after", RST_DC, RST_DC, 5'd0, 1'b0);
    pulse_load(7); wait_idle(n);
    chk_out("7", z, z, 5'd7, 1'b0);

    // Randomized traffic, including loads while busy and occasional resets.
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      load = ($urandom_range(3) == 0);
      case ($urandom_range(7))
        0: valor = BIN_W'(0);
        1: valor = BIN_W'(999);
        2: valor = BIN_W'(1000);
        3: valor = BIN_W'(1023);
        default: valor = BIN_W'($urandom);
      endcase
      if ($urandom_range(499) == 0) begin
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end
    load = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
